// File: rtl/i2c_wr_8bit_ctrl.sv
// i2c_wr_8bit_ctrl -- byte-level I2C master bit engine.
// Executes one command word per handshake: optional START, one byte write or
// read (8 data bits + ACK bit), optional STOP. SCL/SDA are open-drain and are
// driven through o/t pairs (t=1 releases the line, o is tied low).
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   i_cmd_start/wdata/rdata/stop, i_wvalid, i_wdata[7:0], o_wready
//                            command/data handshake
//   o_rvalid, i_rready, o_rdata[7:0]  read byte handshake
//   o_busy, o_done, o_ack    status (o_ack = slave ACKed last written byte)
//   scl_i/sda_i, scl_o/sda_o, scl_t/sda_t  bus line levels and tri-state pairs
module i2c_wr_8bit_ctrl #(
  parameter int CLK_FREQ = 32,
  parameter int I2C_FREQ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_cmd_start,
  input  logic       i_cmd_wdata,
  input  logic       i_cmd_rdata,
  input  logic       i_cmd_stop,
  input  logic       i_wvalid,
  output logic       o_wready,
  input  logic [7:0] i_wdata,
  output logic       o_rvalid,
  input  logic       i_rready,
  output logic [7:0] o_rdata,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_ack,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       scl_t,
  output logic       sda_t
);

  localparam int QDIV_RAW = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QDIV     = (QDIV_RAW < 1) ? 1 : QDIV_RAW;
  localparam int QW       = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QDIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_WRITE, ST_READ, ST_STOP, ST_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;
  logic [1:0]      quarter_q, quarter_d;
  logic [3:0]      bit_q, bit_d;
  logic            c_start_q, c_start_d, c_wr_q, c_wr_d;
  logic            c_rd_q, c_rd_d, c_stop_q, c_stop_d;
  logic [7:0]      wdata_q, wdata_d, shreg_q, shreg_d, rdata_q, rdata_d;
  logic            rvalid_q, rvalid_d, ack_q, ack_d;
  logic            busy_q, busy_d, done_q, done_d, wready_q, wready_d;
  logic            scl_t_q, scl_t_d, sda_t_q, sda_t_d;
  logic            q_end, accept;

  // Phase that follows the current one, skipping phases not requested.
  function automatic state_t next_phase(input state_t cur, input logic wr,
                                        input logic rd, input logic stop);
    state_t n;
    n = ST_DONE;
    if (cur == ST_START || cur == ST_IDLE) begin
      if (wr)        n = ST_WRITE;
      else if (rd)   n = ST_READ;
      else if (stop) n = ST_STOP;
    end else if (cur == ST_WRITE || cur == ST_READ) begin
      if (stop) n = ST_STOP;
    end
    return n;
  endfunction

  always_comb begin
    state_d   = state_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    c_start_d = c_start_q;
    c_wr_d    = c_wr_q;
    c_rd_d    = c_rd_q;
    c_stop_d  = c_stop_q;
    wdata_d   = wdata_q;
    shreg_d   = shreg_q;
    rdata_d   = rdata_q;
    rvalid_d  = rvalid_q;
    ack_d     = ack_q;
    scl_t_d   = scl_t_q;
    sda_t_d   = sda_t_q;
    q_end     = 1'b0;
    accept    = wready_q & (i_cmd_start | i_cmd_wdata | i_cmd_rdata | i_cmd_stop)
              & (~i_cmd_wdata | i_wvalid);

    if (rvalid_q && i_rready) rvalid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          c_start_d = i_cmd_start;
          c_wr_d    = i_cmd_wdata;
          c_rd_d    = i_cmd_rdata & ~i_cmd_wdata;
          c_stop_d  = i_cmd_stop;
          wdata_d   = i_wdata;
          qcnt_d    = '0;
          quarter_d = '0;
          bit_d     = '0;
          state_d   = i_cmd_start ? ST_START
                    : next_phase(ST_IDLE, i_cmd_wdata, c_rd_d, i_cmd_stop);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: begin
        // Slave clock stretching: Q2 holds while SCL is still seen low.
        if (!(quarter_q == 2'd2 && !scl_i)) begin
          if (qcnt_q == QLAST) begin
            qcnt_d = '0;
            q_end  = 1'b1;
          end else begin
            qcnt_d = qcnt_q + QW'(1);
          end
        end
        if (q_end) begin
          quarter_d = quarter_q + 2'd1;
          if (quarter_q == 2'd2) begin
            if (state_q == ST_READ && bit_q < 4'd8) begin
              shreg_d = {shreg_q[6:0], sda_i};
              if (bit_q == 4'd7) begin
                rdata_d  = {shreg_q[6:0], sda_i};
                rvalid_d = 1'b1;
              end
            end
            if (state_q == ST_WRITE && bit_q == 4'd8) ack_d = ~sda_i;
          end
          if (quarter_q == 2'd3) begin
            if ((state_q == ST_WRITE || state_q == ST_READ) && bit_q != 4'd8) begin
              bit_d = bit_q + 4'd1;
            end else begin
              bit_d   = '0;
              state_d = next_phase(state_q, c_wr_q, c_rd_q, c_stop_q);
            end
          end
        end
      end
    endcase

    // Line levels are decoded from the next-state values so the registered
    // outputs change on the same edge the quarter begins.
    unique case (state_d)
      ST_START: begin
        unique case (quarter_d)
          2'd0: sda_t_d = 1'b1;
          2'd1: begin scl_t_d = 1'b1; sda_t_d = 1'b1; end
          2'd2: begin scl_t_d = 1'b1; sda_t_d = 1'b0; end
          default: begin scl_t_d = 1'b0; sda_t_d = 1'b0; end
        endcase
      end
      ST_WRITE: begin
        scl_t_d = quarter_d[1];
        sda_t_d = (bit_d == 4'd8) ? 1'b1 : wdata_d[3'd7 - bit_d[2:0]];
      end
      ST_READ: begin
        scl_t_d = quarter_d[1];
        sda_t_d = (bit_d == 4'd8) ? c_stop_d : 1'b1;
      end
      ST_STOP: begin
        unique case (quarter_d)
          2'd0: begin scl_t_d = 1'b0; sda_t_d = 1'b0; end
          2'd3: begin scl_t_d = 1'b1; sda_t_d = 1'b1; end
          default: begin scl_t_d = 1'b1; sda_t_d = 1'b0; end
        endcase
      end
      ST_DONE: if (!c_stop_d) scl_t_d = 1'b0;
      default: ;
    endcase

    busy_d   = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d   = (state_d == ST_DONE);
    wready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      qcnt_q    <= '0;
      quarter_q <= '0;
      bit_q     <= '0;
      c_start_q <= 1'b0;
      c_wr_q    <= 1'b0;
      c_rd_q    <= 1'b0;
      c_stop_q  <= 1'b0;
      wdata_q   <= '0;
      shreg_q   <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wready_q  <= 1'b0;
      scl_t_q   <= 1'b1;
      sda_t_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      c_start_q <= c_start_d;
      c_wr_q    <= c_wr_d;
      c_rd_q    <= c_rd_d;
      c_stop_q  <= c_stop_d;
      wdata_q   <= wdata_d;
      shreg_q   <= shreg_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wready_q  <= wready_d;
      scl_t_q   <= scl_t_d;
      sda_t_q   <= sda_t_d;
    end
  end

  assign o_wready = wready_q;
  assign o_rvalid = rvalid_q;
  assign o_rdata  = rdata_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_ack    = ack_q;
  assign scl_o    = 1'b0;
  assign sda_o    = 1'b0;
  assign scl_t    = scl_t_q;
  assign sda_t    = sda_t_q;

endmodule

// File: tb/tb_i2c_wr_8bit_ctrl.sv
// Testbench for i2c_wr_8bit_ctrl (CLK_FREQ=32, I2C_FREQ=1 -> 32 clk per bit).
module tb_i2c_wr_8bit_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_cmd_start, i_cmd_wdata, i_cmd_rdata, i_cmd_stop, i_wvalid;
  logic       o_wready;
  logic [7:0] i_wdata;
  logic       o_rvalid, i_rready;
  logic [7:0] o_rdata;
  logic       o_busy, o_done, o_ack;
  logic       scl_i, sda_i, scl_o, sda_o, scl_t, sda_t;

  logic       stretch = 1'b0;
  logic       slave_sda = 1'b1;
  int         slave_kind = 0;   // 0 none, 1 ACK bit 8, 2 drive slave_byte
  int         slave_off = 0;
  logic [7:0] slave_byte = 8'h5A;

  int cyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rv_cnt = 0;

  typedef struct {
    bit   has_ack;
    logic exp_ack;
    int   cycles;
  } done_exp_t;

  done_exp_t  done_q[$];
  logic [7:0] rd_q[$];
  done_exp_t  mon_e;
  logic [7:0] mon_rd;

  i2c_wr_8bit_ctrl #(.CLK_FREQ(32), .I2C_FREQ(1)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_start(i_cmd_start), .i_cmd_wdata(i_cmd_wdata),
    .i_cmd_rdata(i_cmd_rdata), .i_cmd_stop(i_cmd_stop),
    .i_wvalid(i_wvalid), .o_wready(o_wready), .i_wdata(i_wdata),
    .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rdata(o_rdata),
    .o_busy(o_busy), .o_done(o_done), .o_ack(o_ack),
    .scl_i(scl_i), .sda_i(sda_i), .scl_o(scl_o), .sda_o(sda_o),
    .scl_t(scl_t), .sda_t(sda_t)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign scl_i = scl_t & ~stretch;
  assign sda_i = sda_t & slave_sda;

  // Slave: changes SDA at bit boundaries (SCL low) relative to the accept edge.
  always @(negedge clk) begin
    int rel;
    rel = cyc - base - slave_off;
    slave_sda = 1'b1;
    if (rel >= 0) begin
      if (slave_kind == 1 && rel / 32 == 8) slave_sda = 1'b0;
      if (slave_kind == 2 && rel / 32 < 8) slave_sda = slave_byte[7 - rel / 32];
    end
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: pops expectations whenever the DUT presents a completion or a
  // read byte handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got o_done=1 expected no completion");
        end else begin
          mon_e = done_q.pop_front();
          chk("done_latency", cyc - base, mon_e.cycles);
          chk("o_busy_at_done", {31'd0, o_busy}, 32'd0);
          if (mon_e.has_ack) chk("o_ack", {31'd0, o_ack}, {31'd0, mon_e.exp_ack});
        end
      end
      if (o_rvalid) rv_cnt++;
      if (o_rvalid && i_rready) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rvalid: got rdata 0x%0h expected none", o_rdata);
        end else begin
          mon_rd = rd_q.pop_front();
          chk("rdata", {24'd0, o_rdata}, {24'd0, mon_rd});
        end
      end
    end
  end

  task automatic issue(input logic s, input logic w, input logic r, input logic p,
                       input logic [7:0] d, input int kind, input int off,
                       input bit has_ack, input logic exp_ack, input int cycles);
    done_exp_t e;
    int n;
    n = 0;
    while (!o_wready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_wready) begin
      checks++;
      errors++;
      $display("FAIL issue_wready: got o_wready=0 expected 1 within 100 clk");
    end
    if (cycles > 0) begin
      e.has_ack = has_ack;
      e.exp_ack = exp_ack;
      e.cycles  = cycles;
      done_q.push_back(e);
    end
    slave_kind  = 0;
    i_cmd_start = s;
    i_cmd_wdata = w;
    i_cmd_rdata = r;
    i_cmd_stop  = p;
    i_wvalid    = w;
    i_wdata     = d;
    @(posedge clk);
    #1;
    base        = cyc;
    slave_kind  = kind;
    slave_off   = off;
    i_cmd_start = 1'b0;
    i_cmd_wdata = 1'b0;
    i_cmd_rdata = 1'b0;
    i_cmd_stop  = 1'b0;
    i_wvalid    = 1'b0;
  endtask

  task automatic wait_rel(input int target);
    int n;
    n = 0;
    while ((cyc - base) < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if ((cyc - base) != target) begin
      checks++;
      errors++;
      $display("FAIL wait_rel: got rel %0d expected %0d", cyc - base, target);
    end
  endtask

  task automatic wait_done(input int limit);
    int n0;
    int n;
    n0 = done_cnt;
    n  = 0;
    while (done_cnt == n0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt == n0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no o_done expected one within %0d clk", limit);
    end
  endtask

  initial begin
    logic [7:0] pat;
    int n0;
    rst = 1'b1;
    i_cmd_start = 1'b0; i_cmd_wdata = 1'b0; i_cmd_rdata = 1'b0; i_cmd_stop = 1'b0;
    i_wvalid = 1'b0; i_wdata = 8'h00; i_rready = 1'b0;

    // Reset state
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("rst_wready", {31'd0, o_wready}, 32'd0);
    chk("rst_busy",   {31'd0, o_busy},   32'd0);
    chk("rst_done",   {31'd0, o_done},   32'd0);
    chk("rst_rvalid", {31'd0, o_rvalid}, 32'd0);
    chk("rst_rdata",  {24'd0, o_rdata},  32'd0);
    chk("rst_lines",  {30'd0, scl_t, sda_t}, 32'd3);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wready", {31'd0, o_wready}, 32'd1);
    chk("post_rst_busy",   {31'd0, o_busy},   32'd0);

    // Ignored commands: no cmd bit, and write without wvalid
    i_wvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("ignore_nocmd_busy", {31'd0, o_busy}, 32'd0);
    i_wvalid = 1'b0;
    i_cmd_wdata = 1'b1;
    repeat (3) @(negedge clk);
    chk("ignore_nowvalid_busy", {31'd0, o_busy}, 32'd0);
    i_cmd_wdata = 1'b0;
    @(negedge clk);

    // T2: write 0xAA, slave ACKs
    pat = 8'hAA;
    issue(1'b0, 1'b1, 1'b0, 1'b0, pat, 1, 0, 1'b1, 1'b1, 288);
    for (int k = 0; k < 9; k++) begin
      wait_rel(32 * k + 20);
      chk($sformatf("t2_sda_bit%0d", k), {31'd0, sda_t},
          (k < 8) ? {31'd0, pat[7 - k]} : 32'd1);
    end
    chk("t2_scl_high_q2", {31'd0, scl_t}, 32'd1);
    wait_done(400);
    chk("t2_scl_low_after", {31'd0, scl_t}, 32'd0);

    // T3: START + write 0xA0 + STOP, no ACK
    issue(1'b1, 1'b1, 1'b0, 1'b1, 8'hA0, 0, 32, 1'b1, 1'b0, 352);
    wait_rel(20);
    chk("t3_start_cond", {30'd0, scl_t, sda_t}, 32'd2);
    wait_done(500);
    chk("t3_final_lines", {30'd0, scl_t, sda_t}, 32'd3);

    // T4: read + STOP, consumer ready
    i_rready = 1'b1;
    rv_cnt = 0;
    rd_q.push_back(8'h5A);
    issue(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 2, 0, 1'b0, 1'b0, 320);
    wait_rel(32 * 8 + 20);
    chk("t4_nack_sda", {31'd0, sda_t}, 32'd1);
    wait_done(500);
    chk("t4_rvalid_cycles", rv_cnt, 32'd1);
    i_rready = 1'b0;

    // T5: read, consumer stalls
    rd_q.push_back(8'h5A);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 2, 0, 1'b0, 1'b0, 288);
    wait_rel(32 * 8 + 20);
    chk("t5_ack_sda", {31'd0, sda_t}, 32'd0);
    wait_done(500);
    repeat (5) @(negedge clk);
    chk("t5_rvalid_held", {31'd0, o_rvalid}, 32'd1);
    chk("t5_rdata_held",  {24'd0, o_rdata},  32'h5A);
    @(posedge clk);
    #1 i_rready = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_rvalid_cleared", {31'd0, o_rvalid}, 32'd0);
    i_rready = 1'b0;

    // Write and read both set: write executes only
    issue(1'b0, 1'b1, 1'b1, 1'b0, 8'h81, 1, 0, 1'b1, 1'b1, 288);
    wait_done(500);

    // T6: clock stretch of 50 clk in bit 2 Q2
    issue(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 0, 0, 1'b1, 1'b0, 338);
    wait_rel(80);
    stretch = 1'b1;
    repeat (50) @(negedge clk);
    stretch = 1'b0;
    wait_done(600);

    // T6: reset mid-byte abandons the command
    issue(1'b0, 1'b1, 1'b0, 1'b0, 8'h3C, 0, 0, 1'b0, 1'b0, 0);
    wait_rel(10);
    chk("t6_lines_driven", {30'd0, scl_t, sda_t}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_lines",  {30'd0, scl_t, sda_t}, 32'd3);
    chk("t6_rst_busy",   {31'd0, o_busy},   32'd0);
    chk("t6_rst_wready", {31'd0, o_wready}, 32'd0);
    rst = 1'b0;
    n0 = done_cnt;
    repeat (400) @(negedge clk);
    chk("t6_no_done_after_rst", done_cnt, n0);
    chk("t6_idle_busy", {31'd0, o_busy}, 32'd0);

    chk("done_queue_empty", done_q.size(), 32'd0);
    chk("rd_queue_empty",   rd_q.size(),   32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
